count_run_sequencer: RTL and testbench
======================================

# count_run_sequencer

Sequences one counting run of the Adder/Comparator datapath in Project D. On `start` it latches a stop value, clears the count, and advances the count by `STEP` on each `tick` strobe. When the count equals the latched stop value, it pulses `done` and returns to idle. It owns the stop register and the running count, and exposes both the equality result and the run status to the top level.

## Interface
- `WIDTH`, 10, width of count and stop value
- `STEP`, 1, increment applied per accepted tick (1 ≤ STEP < 2^WIDTH)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `stop_val`  in  WIDTH  stop value; latched on accepted `start`
- `tick`  in  1  count-enable strobe; sampled only in RUN
- `abort`  in  1  terminate the run; sampled only in RUN
- `count`  out  WIDTH  registered running count
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse, high only in DONE
- `match`  out  1  combinational `count == stop_reg`

## Operation
- States: IDLE, RUN, DONE. Internal `stop_reg[WIDTH-1:0]`.
- Reset: state=IDLE; count=0; stop_reg=0; busy=0; done=0; match=1, because 0==0.
- IDLE, start=1:
  - stop_reg←stop_val; count←0.
  - If stop_val==0, go to DONE. Otherwise go to RUN.
- IDLE, start=0: hold count and stop_reg.
- RUN, abort=1: go to IDLE, count holds its value, no increment. Abort beats tick in the same cycle.
- RUN, tick=1, abort=0:
  - count←(count+STEP) mod 2^WIDTH.
  - If (count+STEP) mod 2^WIDTH == stop_reg, go to DONE.
- RUN, tick=0: hold.
- `start` is ignored in RUN and DONE. `stop_val` changes after latch have no effect.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. count holds stop_reg.
- Wrap-around: if STEP never lands on stop_reg, the count wraps modulo 2^WIDTH and keeps running until it lands or `abort` is asserted. No error flag.
- Arithmetic is WIDTH bits unsigned; the carry is discarded.

## Timing
- All outputs except `match` are registered.
- `busy` rises in the cycle after the edge that accepts `start`.
- The completion check uses the next-count value. `done` and count==stop_reg therefore appear in the same cycle, and `busy` falls in that cycle.
- With a tick every cycle and STEP=1, `done` is asserted exactly stop_val cycles after the accepting edge.
- With stop_val==0, `done` asserts the cycle after `start`, and `busy` never rises.
- Reset mid-run: the next cycle shows reset values, and no `done` is produced.
- Back-to-back runs: the earliest `start` is accepted in the IDLE cycle following DONE, one dead cycle after `done`.

## Structure
- Shared package `count_seq_pkg` holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default `WIDTH` and `STEP` constants.
- One sub-module, `stop_match`: a parameterised WIDTH-bit equality compare.
  - Instance 1 produces `match` from count vs stop_reg.
  - Instance 2 makes the completion decision from next-count vs stop_reg.
- The FSM, the count register and stop_reg live in the top module.

## Test plan
- Basic run: reset; start with stop_val=3, tick held high → count 1,2,3 on consecutive cycles; done=1 exactly in the count==3 cycle; busy=0 the next cycle.
- Sparse ticks: stop_val=2, tick every third cycle → count advances only on ticks; done coincides with count==2.
- Zero stop: start with stop_val=0 → done=1 the next cycle, busy never 1, count=0.
- Abort priority: stop_val=5, at count=2 assert abort and tick together → state IDLE, count stays 2, no done pulse.
- Wrap: STEP=2, stop_val=1023, WIDTH=10 → count wraps 1022→0 with no done; abort at count=4 → IDLE.
- Reset and ignores:
  - rst at count=7 of a stop_val=20 run → next cycle count=0, busy=0, done=0, match=1.
  - start pulsed during RUN → no effect.

Source files
------------

// File: rtl/count_run_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : count_seq_pkg
// Purpose : Shared constants and types for the counting-run sequencer:
//           state encoding and default datapath width / step.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package count_seq_pkg;

  localparam int unsigned c_DEFAULT_WIDTH = 10;
  localparam int unsigned c_DEFAULT_STEP  = 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_RUN  = c_ST_RUN,
    ST_DONE = c_ST_DONE
  } state_e;

endpackage : count_seq_pkg
`default_nettype wire

// File: rtl/count_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : count_run_sequencer_if
// Purpose : Control/status bundle between a run requester (master) and the
//           counting-run sequencer (slave).
// Ports   : start, stop_val, tick, abort      (master -> slave)
//           count, busy, done, match           (slave  -> master)
// Rev     : 1.0  initial release
// ============================================================================
interface count_run_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = c_DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] stop_val;
  logic             tick;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             match;

  modport master (
    output start, stop_val, tick, abort,
    input  count, busy, done, match
  );

  modport slave (
    input  start, stop_val, tick, abort,
    output count, busy, done, match
  );
endinterface : count_run_sequencer_if
`default_nettype wire

// File: rtl/count_run_sequencer_stop_match.sv
`default_nettype none
// ============================================================================
// Module  : stop_match
// Purpose : WIDTH-bit unsigned equality compare.
// Ports   : a_i, b_i (operands), eq_o (a_i == b_i)
// Rev     : 1.0  initial release
// ============================================================================
module stop_match #(
  parameter int unsigned WIDTH = 10
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic                  eq_o
);
  assign eq_o = (a_i == b_i);
endmodule : stop_match
`default_nettype wire

// File: rtl/count_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : count_run_sequencer
// Purpose : Sequences one counting run: latches a stop value on start, clears
//           the count, advances it by STEP per tick and pulses done when the
//           count lands on the stop value.
// Ports   : clk, rst (sync, active high)
//           bus.slave : start, stop_val, tick, abort in;
//                       count, busy, done (registered), match (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module count_run_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = c_DEFAULT_WIDTH,
  parameter int unsigned STEP  = c_DEFAULT_STEP
) (
  input wire logic              clk,
  input wire logic              rst,
  count_run_sequencer_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] stop_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] count_d;
  logic             hit_w;

  // Carry out of the add is intentionally dropped: the count wraps.
  assign count_d = count_q + c_STEP;

  stop_match #(.WIDTH(WIDTH)) u_match (
    .a_i  (count_q),
    .b_i  (stop_q),
    .eq_o (bus.match)
  );

  // Completion is decided on the next count so done and count==stop
  // become visible in the same cycle.
  stop_match #(.WIDTH(WIDTH)) u_hit (
    .a_i  (count_d),
    .b_i  (stop_q),
    .eq_o (hit_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      stop_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            stop_q  <= bus.stop_val;
            count_q <= '0;
            // A zero stop value is already satisfied by the cleared count.
            if (bus.stop_val == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.tick) begin
            count_q <= count_d;
            if (hit_w) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule : count_run_sequencer
`default_nettype wire

// File: tb/tb_count_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_run_sequencer
// Purpose : Self-checking bench: two sequencers (STEP=1 and STEP=2) share one
//           stimulus stream and are compared every cycle against a
//           behavioural run model, plus directed literal expectations.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_count_run_sequencer;
  import count_seq_pkg::*;

  localparam int unsigned c_W   = 10;
  localparam int          c_MOD = 1 << c_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           d_start = 1'b0;
  logic [c_W-1:0] d_stop  = '0;
  logic           d_tick  = 1'b0;
  logic           d_abort = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  count_run_sequencer_if #(.WIDTH(c_W)) bus1 ();
  count_run_sequencer_if #(.WIDTH(c_W)) bus2 ();

  assign bus1.start = d_start;  assign bus2.start = d_start;
  assign bus1.stop_val = d_stop; assign bus2.stop_val = d_stop;
  assign bus1.tick = d_tick;    assign bus2.tick = d_tick;
  assign bus1.abort = d_abort;  assign bus2.abort = d_abort;

  count_run_sequencer #(.WIDTH(c_W), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  count_run_sequencer #(.WIDTH(c_W), .STEP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Behavioural run model: "running", "done pulse pending", count, stop.
  typedef struct packed {
    bit run;
    bit dn;
    int cnt;
    int stp;
  } mdl_t;

  mdl_t m1 = '0;
  mdl_t m2 = '0;

  function automatic mdl_t mstep(mdl_t m, int step, bit r, bit s, int sv, bit t, bit a);
    mdl_t n;
    n = m;
    if (r) begin
      n = '0;
    end else if (m.dn) begin
      n.dn = 1'b0;
    end else if (m.run) begin
      if (a) begin
        n.run = 1'b0;
      end else if (t) begin
        n.cnt = (m.cnt + step) % c_MOD;
        if (n.cnt == m.stp) begin
          n.run = 1'b0;
          n.dn  = 1'b1;
        end
      end
    end else if (s) begin
      n.stp = sv;
      n.cnt = 0;
      if (sv == 0) n.dn = 1'b1;
      else         n.run = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 = mstep(m1, 1, rst, d_start, int'(d_stop), d_tick, d_abort);
    m2 = mstep(m2, 2, rst, d_start, int'(d_stop), d_tick, d_abort);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m1.count", 32'(bus1.count), 32'(m1.cnt));
      chk("m1.busy",  32'(bus1.busy),  32'(m1.run));
      chk("m1.done",  32'(bus1.done),  32'(m1.dn));
      chk("m1.match", 32'(bus1.match), 32'(m1.cnt == m1.stp));
      chk("m2.count", 32'(bus2.count), 32'(m2.cnt));
      chk("m2.busy",  32'(bus2.busy),  32'(m2.run));
      chk("m2.done",  32'(bus2.done),  32'(m2.dn));
      chk("m2.match", 32'(bus2.match), 32'(m2.cnt == m2.stp));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    d_start = 1'b0; d_tick = 1'b0; d_abort = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic begin_run(input logic [c_W-1:0] sv, input logic tk);
    d_start = 1'b1; d_stop = sv; d_tick = tk; d_abort = 1'b0;
    cyc();
    d_start = 1'b0;
    d_stop  = c_W'($urandom);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst.count", 32'(bus1.count), 0);
    chk("rst.busy",  32'(bus1.busy),  0);
    chk("rst.done",  32'(bus1.done),  0);
    chk("rst.match", 32'(bus1.match), 1);
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic run, stop=3, tick every cycle
    begin_run(10'd3, 1'b1);
    chk("basic.busy0", 32'(bus1.busy), 1);
    chk("basic.cnt0",  32'(bus1.count), 0);
    cyc(); chk("basic.cnt1", 32'(bus1.count), 1);
    cyc(); chk("basic.cnt2", 32'(bus1.count), 2);
    chk("basic.nodone2", 32'(bus1.done), 0);
    cyc(); chk("basic.cnt3", 32'(bus1.count), 3);
    chk("basic.done3", 32'(bus1.done), 1);
    chk("basic.busy3", 32'(bus1.busy), 0);
    cyc(); chk("basic.doneoff", 32'(bus1.done), 0);
    chk("basic.idlebusy", 32'(bus1.busy), 0);
    chk("basic.hold", 32'(bus1.count), 3);

    // Sparse ticks, stop=2, tick every third cycle
    do_reset();
    begin_run(10'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      d_tick = (i % 3 == 2);
      cyc();
      if (i == 2) begin
        chk("sparse.cnt_a", 32'(bus1.count), 1);
        chk("sparse.s2done", 32'(bus2.done), 1);
      end
      if (i == 4) chk("sparse.nodone", 32'(bus1.done), 0);
      if (i == 5) begin
        chk("sparse.cnt_b", 32'(bus1.count), 2);
        chk("sparse.done", 32'(bus1.done), 1);
      end
    end

    // Zero stop value
    do_reset();
    begin_run(10'd0, 1'b1);
    chk("zero.done", 32'(bus1.done), 1);
    chk("zero.busy", 32'(bus1.busy), 0);
    chk("zero.cnt",  32'(bus1.count), 0);
    cyc();
    chk("zero.doneoff", 32'(bus1.done), 0);
    chk("zero.busyoff", 32'(bus1.busy), 0);

    // Abort beats tick
    do_reset();
    begin_run(10'd5, 1'b1);
    cyc(); cyc();
    chk("abort.pre", 32'(bus1.count), 2);
    d_abort = 1'b1;
    cyc();
    d_abort = 1'b0; d_tick = 1'b0;
    chk("abort.cnt",  32'(bus1.count), 2);
    chk("abort.busy", 32'(bus1.busy), 0);
    chk("abort.cnt2", 32'(bus2.count), 4);
    cyc();
    chk("abort.nodone", 32'(bus1.done), 0);

    // Wrap with STEP=2, stop=1023 (never landed on)
    do_reset();
    begin_run(10'd1023, 1'b1);
    for (int k = 1; k <= 514; k++) begin
      cyc();
      if (k == 511) chk("wrap.1022", 32'(bus2.count), 1022);
      if (k == 512) begin
        chk("wrap.zero", 32'(bus2.count), 0);
        chk("wrap.busy", 32'(bus2.busy), 1);
      end
    end
    chk("wrap.four", 32'(bus2.count), 4);
    d_abort = 1'b1;
    cyc();
    d_abort = 1'b0; d_tick = 1'b0;
    chk("wrap.abort", 32'(bus2.busy), 0);
    chk("wrap.hold", 32'(bus2.count), 4);

    // Ignored start during RUN, then reset mid-run
    do_reset();
    begin_run(10'd20, 1'b1);
    cyc(); cyc();
    d_start = 1'b1; d_stop = 10'd3;
    cyc();
    d_start = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("ign.cnt7", 32'(bus1.count), 7);
    chk("ign.busy", 32'(bus1.busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; d_tick = 1'b0;
    chk("mrst.count", 32'(bus1.count), 0);
    chk("mrst.busy",  32'(bus1.busy), 0);
    chk("mrst.done",  32'(bus1.done), 0);
    chk("mrst.match", 32'(bus1.match), 1);

    // Back-to-back runs: start held high throughout
    d_start = 1'b1; d_stop = 10'd1; d_tick = 1'b1;
    cyc(); chk("b2b.run",  32'(bus1.busy), 1);
    cyc(); chk("b2b.done", 32'(bus1.done), 1);
    cyc(); chk("b2b.dead", 32'(bus1.busy), 0);
    cyc(); chk("b2b.again", 32'(bus1.busy), 1);
    d_start = 1'b0;

    // Random traffic checked by the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(63) == 0);
      d_start = ($urandom_range(3) == 0);
      d_stop  = ($urandom_range(7) == 0) ? c_W'($urandom) : c_W'($urandom_range(12));
      d_tick  = ($urandom_range(1) == 0);
      d_abort = ($urandom_range(15) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_count_run_sequencer
`default_nettype wire
